// File: rtl/uart_rx_sniffer.sv
// uart_rx_sniffer: 8N1 UART receiver with a small first-word-fall-through
// byte FIFO, frame-error pulse and sticky overflow flag.
//
// Output handshake: a byte is transferred on every rising clk edge where
// m_valid && m_ready; m_valid stays high and m_data stays stable until that
// happens, and m_valid never depends combinationally on m_ready.
module uart_rx_sniffer #(
    parameter int CLKS_PER_BIT = 20,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       overflow,
    input  logic       clr_overflow,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    // Synchronizer and start-edge qualification
    logic       rx_meta_q;
    logic       rx_s_q;
    logic [1:0] sync_vld_q;
    logic       rx_high_q;
    logic       start_edge;

    // Receiver FSM
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        push;
    logic        frame_err_q, frame_err_d;

    // FIFO
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q, count_d;
    logic        full;
    logic        pop;
    logic        wr_en;
    logic        overflow_q, overflow_d;

    // rx_s is only trusted once real line samples have flushed the reset
    // value out of the synchronizer, so a line held low through reset
    // release can never look like a start edge.
    assign start_edge = sync_vld_q[1] & rx_high_q & ~rx_s_q;

    // Two-flop synchronizer plus "line was high last cycle" tracker
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            sync_vld_q <= 2'b00;
            rx_high_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            rx_high_q  <= sync_vld_q[1] & rx_s_q;
        end
    end

    // Next-state logic: mid-bit sampling driven by one bit counter
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_START;
                    cnt_d   = 16'd0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 16'd0;
                    idx_d = 3'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = 16'd0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 16'd0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Receiver state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    // A push into a full FIFO only lands if a pop frees a slot that same edge
    assign full  = (count_q == FULL_CNT);
    assign pop   = m_valid & m_ready;
    assign wr_en = push & (~full | pop);

    // FIFO occupancy and sticky overflow (set beats clear)
    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // FIFO pointers and counters; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign m_valid   = (count_q != '0);
    assign m_data    = m_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: doc/uart_rx_sniffer.md
UART_RX_SNIFFER -- requirements
Module: uart_rx_sniffer

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 20, meaning clk cycles per UART bit (400 ns bit at 50 MHz); legal range 4..65535.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, meaning received-byte buffer entries; power of two, 2..16.
REQ-003 SHALL provide port clk  input  1  single clock for all logic, rising edge.
REQ-004 SHALL provide port resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide port rx  input  1  serial line (SoC uart_tx), idle high, 8N1, LSB first, asynchronous to clk.
REQ-006 SHALL provide port m_data  output  8  head-of-FIFO byte, first-word fall-through.
REQ-007 SHALL provide port m_valid  output  1  FIFO non-empty.
REQ-008 SHALL provide port m_ready  input  1  consumer accepts m_data when m_valid&m_ready at a rising edge.
REQ-009 SHALL provide port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL provide port overflow  output  1  sticky, a good byte was dropped because the FIFO was full.
REQ-011 SHALL provide port clr_overflow  input  1  synchronous clear of overflow.
REQ-012 SHALL provide port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (rx_s); both flops reset to 1.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH, with one bit counter (0..CLKS_PER_BIT-1) and one 3-bit bit index.
REQ-015 IDLE: start edge = rx_s==0 with the previous rx_s==1; on edge, cycle T, go to START and clear the counter.
REQ-016 START: sample rx_s at T+CLKS_PER_BIT/2 (integer floor); if 1, false start, return to IDLE with no output; if 0, go to DATA.
REQ-017 DATA: sample bit i (i=0..7) at T+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT into shift position i; after bit 7 go to STOP.
REQ-018 STOP: sample at T+CLKS_PER_BIT/2+9*CLKS_PER_BIT; if 1, push byte and go to IDLE the next cycle (back-to-back frames supported).
REQ-019 STOP sampled 0: frame_err high for exactly one cycle, byte discarded, go to WAIT_HIGH.
REQ-020 WAIT_HIGH: stay until rx_s==1, then go to IDLE; a low line (break) never generates a start.
REQ-021 Push SHALL make m_valid=1 with the byte on m_data on the cycle after the stop sample when the FIFO was empty.
REQ-022 Pop SHALL occur on m_valid&m_ready; m_data then shows the next entry, or m_valid=0 if empty.
REQ-023 Push with FIFO full and no simultaneous pop: byte dropped, overflow set, FIFO contents unchanged.
REQ-024 Push with FIFO full and simultaneous pop: both occur, count unchanged, overflow not set.
REQ-025 Push with FIFO empty and m_ready=1: byte is not bypassed; it is visible for at least one cycle.
REQ-026 clr_overflow and an overflow event in the same cycle: overflow remains 1 (set wins).
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; count is held in log2(FIFO_DEPTH)+1 bits.

Reset
REQ-028 While resetn=0: state IDLE, counters 0, FIFO empty, m_data=0x00, m_valid=0, frame_err=0, overflow=0, busy=0, synchronizer=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no byte and no frame_err.
REQ-030 After release, a start SHALL only be detected after rx_s has been seen high, so a low line at release produces nothing.

Verification (CLKS_PER_BIT=20, FIFO_DEPTH=4)
REQ-031 Send 0x55 then 0xA3 back-to-back, m_ready=1 -> m_data 0x55 then 0xA3, each m_valid rising at T+191 relative to its own start edge, frame_err=0.
REQ-032 rx low pulse of 5 cycles -> no byte, busy returns to 0, state IDLE.
REQ-033 Frame 0x41 with stop bit 0, line held low for 40 more cycles, then high -> one frame_err pulse, no byte, no new start until rx high; the next frame 0x42 is received correctly.
REQ-034 Five frames 0x01..0x05 with m_ready=0 -> FIFO holds 0x01..0x04, 0x05 dropped, overflow=1; drain yields exactly 0x01..0x04; clr_overflow -> overflow=0.
REQ-035 FIFO full, m_ready pulses on the stop-sample cycle of a 6th frame 0x06 -> 0x01 popped, 0x06 stored last, overflow stays 0.
REQ-036 resetn low during bit 3 of a frame, released with rx low -> no byte, no frame_err, all outputs at reset values; the next valid frame is received correctly.
